// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready and all status outputs decode registered state only, so upstream never sees out_ready combinationally.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // skid keeps stale contents; it is unreachable until refilled from FULL entry
            state_d = S_EMPTY;
            main_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        skid_d  = in_data;
                        state_d = S_FULL;
                    end else if (out_ready) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = (state_q != S_FULL);
    assign out_data  = main_q;
    assign occupancy = {state_q == S_FULL, state_q == S_ONE};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, streaming sequence,
// then randomized traffic against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 64;
    localparam logic [DW-1:0] RV = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [DW-1:0] BV = 64'h0000_0000_0000_0013;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pipe_stage_skid #(
        .DATA_W    (DW),
        .RESET_VAL (RV),
        .BUBBLE_VAL(BV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          fl;
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ov;
        logic          ir;
        logic [1:0]    occ;
        logic [DW-1:0] od;
    } vec_t;

    vec_t vt[16];

    // Reference model: FIFO of held beats plus the last value shown on out_data.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] mlast;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                         input logic o);
        reset     = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ov, input logic ir,
                                 input logic [1:0] occ, input logic [DW-1:0] od);
        chk({tag, ".out_valid"}, DW'(out_valid), DW'(ov));
        chk({tag, ".in_ready"}, DW'(in_ready), DW'(ir));
        chk({tag, ".occupancy"}, DW'(occupancy), DW'(occ));
        chk({tag, ".out_data"}, out_data, od);
    endtask

    // Advance the model using the inputs that were present at the last clock edge.
    task automatic model_step();
        bit had, cons, acc;
        if (!reset) begin
            mq.delete();
            mlast = RV;
        end else if (flush) begin
            mq.delete();
            mlast = BV;
        end else begin
            had  = (mq.size() > 0);
            acc  = in_valid && (mq.size() < 2);
            cons = had && out_ready;
            if (cons) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            if (mq.size() > 0) mlast = mq[0];
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

        //          rst   fl    iv    id                    ordy  ov    ir    occ    od
        vt[0]  = '{1'b0, 1'b0, 1'b1, 64'hDEAD,            1'b0, 1'b0, 1'b1, 2'd0, RV};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 64'hDEAD,            1'b0, 1'b0, 1'b1, 2'd0, RV};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 64'hDEAD,            1'b0, 1'b1, 1'b1, 2'd1, 64'hDEAD};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 64'hB1,              1'b0, 1'b1, 1'b0, 2'd2, 64'hDEAD};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 64'hC1,              1'b0, 1'b1, 1'b0, 2'd2, 64'hDEAD};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 64'h0,               1'b1, 1'b1, 1'b1, 2'd1, 64'hB1};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 64'hC1,              1'b1, 1'b1, 1'b1, 2'd1, 64'hC1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 64'h0,               1'b1, 1'b0, 1'b1, 2'd0, 64'hC1};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 64'hA2,              1'b0, 1'b1, 1'b1, 2'd1, 64'hA2};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 64'hB2,              1'b0, 1'b1, 1'b0, 2'd2, 64'hA2};
        vt[10] = '{1'b1, 1'b1, 1'b1, 64'h77,              1'b0, 1'b0, 1'b1, 2'd0, BV};
        vt[11] = '{1'b1, 1'b0, 1'b0, 64'h0,               1'b1, 1'b0, 1'b1, 2'd0, BV};
        vt[12] = '{1'b1, 1'b0, 1'b1, 64'hE3,              1'b0, 1'b1, 1'b1, 2'd1, 64'hE3};
        vt[13] = '{1'b1, 1'b0, 1'b1, 64'hF3,              1'b0, 1'b1, 1'b0, 2'd2, 64'hE3};
        vt[14] = '{1'b0, 1'b1, 1'b1, 64'h99,              1'b0, 1'b0, 1'b1, 2'd0, RV};
        vt[15] = '{1'b1, 1'b0, 1'b1, 64'h55,              1'b1, 1'b1, 1'b1, 2'd1, 64'h55};

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy);
            tick();
            check_outputs($sformatf("vec%0d", i), vt[i].ov, vt[i].ir, vt[i].occ, vt[i].od);
        end

        // Drain the 0x55 beat, then stream 1..8 at full throughput.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        check_outputs("drain", 1'b0, 1'b1, 2'd0, 64'h55);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("stream%0d.in_ready_pre", i), DW'(in_ready), DW'(1'b1));
            drive(1'b1, 1'b0, 1'b1, DW'(i), 1'b1);
            tick();
            check_outputs($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, DW'(i));
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        check_outputs("stream_end", 1'b0, 1'b1, 2'd0, 64'd8);

        // Randomized traffic; start with a reset cycle so model and DUT agree.
        mq.delete();
        mlast = RV;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        model_step();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(99, 0) >= 2), ($urandom_range(99, 0) < 4),
                  ($urandom_range(99, 0) < 65), {$urandom, $urandom},
                  ($urandom_range(99, 0) < 55));
            tick();
            model_step();
            check_outputs($sformatf("rand%0d", n), (mq.size() > 0), (mq.size() < 2),
                          2'(mq.size()), (mq.size() > 0) ? mq[0] : mlast);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register: successor to the fixed IF/ID latch.
- Carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake, a 2-entry skid buffer and a flush/bubble insertion mode.
- Upstream can stall without a combinational ready path: in_ready is a registered signal.
- Instanced between every pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with width set per stage.

Parameters:
- DATA_W, 64, payload width in bits (e.g. PC+4 concatenated with instruction).
- RESET_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset.
- BUBBLE_VAL, {DATA_W{1'b0}}, value loaded into the output register on flush (NOP encoding).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- flush  input  1  discard all held and incoming beats; emit bubble.
- in_valid  input  1  upstream beat present.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  stage can accept a beat this cycle (registered).
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  DATA_W  payload to downstream (registered, main register).
- out_ready  input  1  downstream accepts the beat this cycle.
- occupancy  output  2  number of beats held: 0, 1 or 2.

Behaviour:
- Storage: main register (drives out_data) and skid register. Three states: EMPTY (0 beats), ONE (main holds a beat), FULL (main and skid both hold beats).
- Derived outputs, all from registers:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - occupancy = 0, 1 or 2 matching the state.
- Beat definitions: an in-beat is accepted when in_valid && in_ready. An out-beat is consumed when out_valid && out_ready.
- Reset (reset==0 at a clk edge):
  - State goes to EMPTY; main and skid are loaded with RESET_VAL.
  - Outputs after the edge: out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
  - Reset overrides flush and every handshake.
- Flush (reset==1, flush==1):
  - State goes to EMPTY; main is loaded with BUBBLE_VAL; skid is unchanged but treated as invalid.
  - Any in-beat offered in the same cycle is dropped, even though in_ready may be 1.
  - Flush overrides all transitions below.
- Transitions (no reset, no flush):
  - EMPTY:
    - in_valid=1: main <= in_data, go to ONE.
    - Otherwise hold; main keeps its last value.
  - ONE:
    - in_valid=1, out_ready=1: main <= in_data, stay ONE (full throughput).
    - in_valid=1, out_ready=0: skid <= in_data, go to FULL.
    - in_valid=0, out_ready=1: go to EMPTY; main keeps its value.
    - in_valid=0, out_ready=0: hold.
  - FULL (in_ready=0, in_valid ignored):
    - out_ready=1: main <= skid, go to ONE.
    - Otherwise hold.
- Latency and throughput: 1 cycle from an accepted in-beat to out_valid. Sustained throughput is 1 beat/cycle with out_ready held high.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except on flush or reset.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid stay stable.
- No combinational path from out_ready to in_ready.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=64'hDEAD -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL; release, next cycle accepts 64'hDEAD and out_valid=1 one cycle later.
- Streaming: out_ready=1, drive 8 consecutive beats 1..8 -> out_data shows 1..8 on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1 throughout.
- Back-pressure: with beat A in ONE, drop out_ready and offer beat B -> occupancy=2, in_ready=0; offer C while FULL -> C not accepted. Raise out_ready -> A, then B, then C (after re-offer) in order.
- Flush while FULL: flush=1 with in_valid=1, in_data=0x77 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL; 0x77 never appears at the output.
- Simultaneous: in ONE, in_valid=1 and out_ready=1 on the same cycle -> old beat consumed, new beat loaded, occupancy stays 1.
- Reset during FULL with flush=1 -> out_data=RESET_VAL (not BUBBLE_VAL), occupancy=0.
